// File: rtl/wb_ram_pkg.sv
// Shared definitions for the Wishbone wait-state RAM.
//   state_e        : bus FSM states (IDLE / WAIT / ACK)
//   rsrc_e         : which source drives rdt during an ack
//   EXIT_ADDR_DEF  : default word address of the firmware exit mailbox
//   EXIT_VALUE_DEF : default mailbox value that marks firmware completion
//   WCNT_W         : width of the wait-state down-counter
package wb_ram_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACK
   } state_e;

   typedef enum logic [1:0] {
      RSRC_ZERO,
      RSRC_RAM,
      RSRC_MBX
   } rsrc_e;

   localparam logic [29:0] EXIT_ADDR_DEF  = 30'h0400_0001;
   localparam logic [31:0] EXIT_VALUE_DEF = 32'h0000_00AD;
   localparam int          WCNT_W         = 4;

endpackage

// File: rtl/ram_1rw_be.sv
// Single-port 32-bit RAM with per-byte write enables and synchronous read.
//   clk   : clock
//   en    : access strobe; nothing happens without it
//   we    : write (1) / read (0)
//   be    : byte-lane write enables
//   addr  : word index
//   wdata : write data
//   rdata : registered read data, updated on a read access
// The array is never cleared.
module ram_1rw_be #(
  parameter int    ADDR_BITS = 17,
  parameter string INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [3:0]           be,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/wb_wait_ram.sv
// Wishbone-classic slave memory with programmable wait states, firmware exit
// mailbox and a run-cycle counter that freezes when firmware signals completion.
//   clk, resetn : clock, asynchronous active-low reset
//   adr/dat/sel/we/cyc : master request (word address, write data, lanes, dir, strobe)
//   rdt, ack    : read data (valid while ack) and single-cycle acknowledge
//   done        : sticky completion flag from the mailbox
//   exit_code   : last byte 0 written to the mailbox
//   cycles      : clocks since reset release, frozen once done is set
module wb_wait_ram
   import wb_ram_pkg::*;
#(
   parameter int          ADDR_BITS   = 17,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [29:0] EXIT_ADDR   = EXIT_ADDR_DEF,
   parameter logic [31:0] EXIT_VALUE  = EXIT_VALUE_DEF,
   parameter string       INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [29:0] adr,
   input  logic [31:0] dat,
   input  logic [3:0]  sel,
   input  logic        we,
   input  logic        cyc,
   output logic [31:0] rdt,
   output logic        ack,
   output logic        done,
   output logic [7:0]  exit_code,
   output logic [31:0] cycles
);

   localparam bit NO_WAIT = (WAIT_CYCLES == 0);

   state_e              state;
   logic [WCNT_W-1:0]   cnt;
   rsrc_e               rsrc;

   logic [29:0]         adr_q;
   logic [31:0]         dat_q;
   logic [3:0]          sel_q;
   logic                we_q;
   logic [8:0]          mbx_rd_q;

   logic                from_idle;
   logic                commit;
   logic [29:0]         c_adr;
   logic [31:0]         c_dat;
   logic [3:0]          c_sel;
   logic                c_we;
   logic                c_is_mbx;
   logic                c_in_range;
   logic                ram_en;
   logic [31:0]         ram_q;

   // With no wait states the commit happens on the sampling edge itself, so
   // the live bus values are used; otherwise the latched request is used.
   assign from_idle  = (state == IDLE);
   assign commit     = cyc && ((from_idle && NO_WAIT) || (state == WAIT && cnt == '0));
   assign c_adr      = from_idle ? adr : adr_q;
   assign c_dat      = from_idle ? dat : dat_q;
   assign c_sel      = from_idle ? sel : sel_q;
   assign c_we       = from_idle ? we  : we_q;
   assign c_is_mbx   = (c_adr == EXIT_ADDR);
   assign c_in_range = ((c_adr >> ADDR_BITS) == 30'd0);
   assign ram_en     = commit && c_in_range && !c_is_mbx;

   ram_1rw_be #(
      .ADDR_BITS (ADDR_BITS),
      .INIT_FILE (INIT_FILE)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (c_we),
      .be    (c_sel),
      .addr  (c_adr[ADDR_BITS-1:0]),
      .wdata (c_dat),
      .rdata (ram_q)
   );

   // Read data is selected between registered sources captured on the commit
   // edge; the RAM output register cannot be reset, so the source select is.
   always_comb begin
      rdt = 32'd0;
      case (rsrc)
         RSRC_RAM: rdt = ram_q;
         RSRC_MBX: rdt = {23'd0, mbx_rd_q};
         default:  rdt = 32'd0;
      endcase
   end

   // Bus FSM: ACK always returns to IDLE, so a held cyc cannot produce
   // back-to-back acks.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         cnt   <= '0;
         ack   <= 1'b0;
      end else begin
         ack <= 1'b0;
         case (state)
            IDLE: begin
               if (cyc) begin
                  if (NO_WAIT) begin
                     state <= ACK;
                     ack   <= 1'b1;
                  end else begin
                     state <= WAIT;
                     cnt   <= WCNT_W'(WAIT_CYCLES - 1);
                  end
               end
            end
            WAIT: begin
               if (!cyc) begin
                  state <= IDLE;
               end else if (cnt == '0) begin
                  state <= ACK;
                  ack   <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ACK: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Mailbox, read-source select and run-cycle counter. The counter still
   // advances on the mailbox edge (done is old there), then stays frozen.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         done      <= 1'b0;
         exit_code <= 8'd0;
         cycles    <= 32'd0;
         rsrc      <= RSRC_ZERO;
      end else begin
         if (!done && cycles != 32'hFFFF_FFFF) cycles <= cycles + 32'd1;
         if (commit) begin
            if (c_we)            rsrc <= RSRC_ZERO;
            else if (c_is_mbx)   rsrc <= RSRC_MBX;
            else if (c_in_range) rsrc <= RSRC_RAM;
            else                 rsrc <= RSRC_ZERO;
            if (c_we && c_is_mbx) begin
               if (c_sel[0]) exit_code <= c_dat[7:0];
               if (c_sel == 4'hF && c_dat == EXIT_VALUE) done <= 1'b1;
            end
         end
      end
   end

   // Request capture and mailbox read snapshot (data only, no reset).
   always_ff @(posedge clk) begin
      if (from_idle && cyc) begin
         adr_q <= adr;
         dat_q <= dat;
         sel_q <= sel;
         we_q  <= we;
      end
      if (commit) mbx_rd_q <= {done, exit_code};
   end

endmodule

// File: tb/tb_wb_wait_ram.sv
// Scoreboard bench: three instances (0, 1 and 3 wait states) share clock and
// reset. Each request pushes its expected response computed by a word/byte
// memory model; a negedge monitor pops and compares on every ack.
module tb_wb_wait_ram;

   localparam int          NI  = 3;
   localparam int          WC [NI] = '{0, 1, 3};
   localparam logic [29:0] EXA = 30'h0400_0001;

   typedef struct {
      logic        chk_rd;
      logic [31:0] data;
      int          ack_edge;
      logic        chk_mbx;
      logic [7:0]  mbx_code;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [29:0] adr [NI];
   logic [31:0] dat [NI];
   logic [3:0]  sel [NI];
   logic        we  [NI];
   logic        cyc [NI];
   logic [31:0] rdt [NI];
   logic        ack [NI];
   logic        done [NI];
   logic [7:0]  exit_code [NI];
   logic [31:0] cycles [NI];

   exp_t        sbq [NI][$];
   logic [31:0] ref_mem [int];
   logic        m_done [NI];
   logic [7:0]  m_exit [NI];
   logic        prev_ack [NI];

   int checks = 0;
   int errors = 0;
   int edge_cnt = 0;
   int since_rst = 0;
   int saved_cyc = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      wb_wait_ram #(
         .ADDR_BITS   (17),
         .WAIT_CYCLES (WC[g]),
         .EXIT_ADDR   (EXA),
         .EXIT_VALUE  (32'h0000_00AD),
         .INIT_FILE   ("")
      ) u_dut (
         .clk       (clk),
         .resetn    (resetn),
         .adr       (adr[g]),
         .dat       (dat[g]),
         .sel       (sel[g]),
         .we        (we[g]),
         .cyc       (cyc[g]),
         .rdt       (rdt[g]),
         .ack       (ack[g]),
         .done      (done[g]),
         .exit_code (exit_code[g]),
         .cycles    (cycles[g])
      );
   end

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) since_rst <= 0;
      else         since_rst <= since_rst + 1;
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Behavioural memory: returns the expected read data and applies writes.
   function automatic logic [31:0] model(int g, logic w, logic [29:0] a,
                                         logic [31:0] d, logic [3:0] s);
      int          key;
      logic [31:0] r;
      logic [31:0] old;
      key = g * (1 << 20) + int'(a[16:0]);
      r = 32'd0;
      if (a == EXA) begin
         if (w) begin
            if (s[0]) m_exit[g] = d[7:0];
            if (s == 4'hF && d == 32'hAD) m_done[g] = 1'b1;
         end else begin
            r = {23'd0, m_done[g], m_exit[g]};
         end
      end else if (a < 30'h0002_0000) begin
         if (w) begin
            old = ref_mem.exists(key) ? ref_mem[key] : 32'd0;
            for (int i = 0; i < 4; i++) if (s[i]) old[8*i +: 8] = d[8*i +: 8];
            ref_mem[key] = old;
         end else begin
            r = ref_mem.exists(key) ? ref_mem[key] : 32'hxxxx_xxxx;
         end
      end
      return r;
   endfunction

   always @(negedge clk) begin : mon
      exp_t e;
      for (int g = 0; g < NI; g++) begin
         if (resetn && ack[g]) begin
            check($sformatf("ack_gap[%0d]", g), 32'(prev_ack[g]), 32'd0);
            if (sbq[g].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack[%0d]: got ack=1 required no ack", g);
            end else begin
               e = sbq[g].pop_front();
               check($sformatf("ack_latency[%0d]", g), 32'(edge_cnt), 32'(e.ack_edge));
               if (e.chk_rd) check($sformatf("rdt[%0d]", g), rdt[g], e.data);
               if (e.chk_mbx) begin
                  check("mbx_done", 32'(done[g]), 32'd1);
                  check("mbx_exit_code", 32'(exit_code[g]), 32'(e.mbx_code));
                  check("mbx_cycles", cycles[g], 32'(since_rst));
                  saved_cyc <= since_rst;
               end
            end
         end
         prev_ack[g] <= ack[g];
      end
   end

   task automatic xfer(int g, logic w, logic [29:0] a, logic [31:0] d, logic [3:0] s);
      exp_t e;
      int   n;
      @(negedge clk);
      e.data     = model(g, w, a, d, s);
      e.chk_rd   = !w;
      e.chk_mbx  = w && (a == EXA) && (s == 4'hF) && (d == 32'hAD);
      e.mbx_code = d[7:0];
      e.ack_edge = edge_cnt + 1 + WC[g];
      sbq[g].push_back(e);
      adr[g] = a; dat[g] = d; sel[g] = s; we[g] = w; cyc[g] = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ack[g] && n < 40);
      if (!ack[g]) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout[%0d]: got no ack in %0d cycles required ack", g, n);
      end
      cyc[g] = 1'b0;
   endtask

   // cyc held high for 10 cycles on a zero-wait instance: acks on every
   // second edge starting with the sampling edge.
   task automatic held_read(logic [29:0] a);
      exp_t e;
      @(negedge clk);
      e.data = model(0, 1'b0, a, 32'd0, 4'hF);
      e.chk_rd = 1'b1;
      e.chk_mbx = 1'b0;
      e.mbx_code = 8'd0;
      for (int k = 0; k < 5; k++) begin
         e.ack_edge = edge_cnt + 1 + 2 * k;
         sbq[0].push_back(e);
      end
      adr[0] = a; we[0] = 1'b0; sel[0] = 4'hF; cyc[0] = 1'b1;
      repeat (10) @(negedge clk);
      cyc[0] = 1'b0;
   endtask

   task automatic abort_write(logic [29:0] a, logic [31:0] d);
      int seen;
      seen = 0;
      @(negedge clk);
      adr[2] = a; dat[2] = d; sel[2] = 4'hF; we[2] = 1'b1; cyc[2] = 1'b1;
      @(negedge clk);
      cyc[2] = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (ack[2]) seen++;
      end
      check("abort_no_ack", 32'(seen), 32'd0);
   endtask

   task automatic rand_phase(int g);
      logic [29:0] a;
      for (int k = 0; k < 8; k++) xfer(g, 1'b1, 30'h100 + 30'(k), $urandom, 4'hF);
      for (int k = 0; k < 30; k++) begin
         a = 30'h100 + 30'($urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) a = a | 30'h0002_0000;
         xfer(g, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      end
   endtask

   initial begin
      for (int g = 0; g < NI; g++) begin
         adr[g] = '0; dat[g] = '0; sel[g] = '0; we[g] = 1'b0; cyc[g] = 1'b0;
         m_done[g] = 1'b0; m_exit[g] = 8'd0; prev_ack[g] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < NI; g++) begin
         check($sformatf("rst_ack[%0d]", g), 32'(ack[g]), 32'd0);
         check($sformatf("rst_rdt[%0d]", g), rdt[g], 32'd0);
         check($sformatf("rst_done[%0d]", g), 32'(done[g]), 32'd0);
         check($sformatf("rst_exit[%0d]", g), 32'(exit_code[g]), 32'd0);
         check($sformatf("rst_cycles[%0d]", g), cycles[g], 32'd0);
      end
      @(negedge clk);
      resetn = 1'b1;

      // read after write, byte lanes, out of range (one wait state)
      xfer(1, 1'b1, 30'h10, 32'hDEAD_BEEF, 4'hF);
      xfer(1, 1'b0, 30'h10, 32'd0, 4'hF);
      xfer(1, 1'b1, 30'h20, 32'h1122_3344, 4'hF);
      xfer(1, 1'b1, 30'h20, 32'hAABB_CCDD, 4'b0101);
      xfer(1, 1'b0, 30'h20, 32'd0, 4'hF);
      xfer(1, 1'b0, 30'h0100_0000, 32'd0, 4'hF);
      xfer(1, 1'b1, 30'h0100_0010, 32'hBAD0_BAD0, 4'hF);
      xfer(1, 1'b0, 30'h10, 32'd0, 4'hF);

      // held cyc, zero wait states
      xfer(0, 1'b1, 30'h10, 32'h0BAD_CAFE, 4'hF);
      held_read(30'h10);

      // abort in WAIT, three wait states
      xfer(2, 1'b1, 30'h30, 32'h1234_5678, 4'hF);
      abort_write(30'h30, 32'h5555_5555);
      xfer(2, 1'b0, 30'h30, 32'd0, 4'hF);

      for (int g = 0; g < NI; g++) rand_phase(g);

      // exit mailbox after at least 500 cycles
      while (since_rst < 500) @(negedge clk);
      xfer(1, 1'b1, EXA, 32'h0000_00AD, 4'hF);
      repeat (20) @(negedge clk);
      check("cycles_frozen", cycles[1], 32'(saved_cyc));
      check("cycles_running", cycles[0], 32'(since_rst));
      xfer(1, 1'b0, EXA, 32'd0, 4'hF);

      // reset while a write waits
      xfer(2, 1'b1, 30'h40, 32'hCAFE_F00D, 4'hF);
      @(negedge clk);
      adr[2] = 30'h40; dat[2] = 32'h7777_7777; sel[2] = 4'hF; we[2] = 1'b1; cyc[2] = 1'b1;
      repeat (2) @(negedge clk);
      resetn = 1'b0;
      #1;
      check("reset_ack", 32'(ack[2]), 32'd0);
      check("reset_done", 32'(done[1]), 32'd0);
      check("reset_cycles", cycles[1], 32'd0);
      cyc[2] = 1'b0;
      for (int g = 0; g < NI; g++) begin
         m_done[g] = 1'b0;
         m_exit[g] = 8'd0;
      end
      @(negedge clk);
      resetn = 1'b1;
      xfer(2, 1'b0, 30'h40, 32'd0, 4'hF);

      repeat (5) @(negedge clk);
      for (int g = 0; g < NI; g++) check($sformatf("sb_empty[%0d]", g), 32'(sbq[g].size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish required finish within time limit");
      $fatal(1);
   end

endmodule
